hi_fanout_tree: RTL

HI_FANOUT_TREE -- requirements
Module: hi_fanout_tree

---
 rtl/hi_fanout_pkg.sv | 51 +++++
 rtl/hi_fanout_stage.sv | 39 +++
 rtl/hi_fanout_tree.sv | 118 +++++++++++
 3 files changed

// File: rtl/hi_fanout_pkg.sv
// Shared constants and elaboration-time helpers for the high-fanout distribution tree.
// The helpers size the tree: depth, nodes per level and flat slot offsets.
package hi_fanout_pkg;

    localparam int CNT_W = 16;

    function automatic int pow_int(input int base, input int exp);
        int r;
        r = 32'sd1;
        for (int i = 0; i < exp; i++) begin
            r = r * base;
        end
        return r;
    endfunction

    // Smallest depth (at least one level) whose full fanout reaches n loads.
    function automatic int clog_branch(input int n, input int b);
        int lv;
        lv = 32'sd1;
        while ((pow_int(b, lv) < n) && (lv < 32'sd32)) begin
            lv = lv + 32'sd1;
        end
        return lv;
    endfunction

    function automatic int min_int(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Loads covered by one node at level lvl; level levels+1 is the load level itself.
    function automatic int span_at(input int b, input int levels, input int lvl);
        return pow_int(b, levels - lvl + 32'sd1);
    endfunction

    function automatic int nodes_at(input int n, input int b, input int levels, input int lvl);
        int span;
        span = span_at(b, levels, lvl);
        return (n + span - 32'sd1) / span;
    endfunction

    // Offset of the first slot feeding level lvl in the flat slot vectors.
    function automatic int slot_base(input int n, input int b, input int levels, input int lvl);
        int acc;
        acc = 32'sd0;
        for (int t = 1; t < lvl; t++) begin
            acc = acc + nodes_at(n, b, levels, t);
        end
        return acc;
    endfunction

endpackage

// File: rtl/hi_fanout_stage.sv
// One tree node: a single registered copy of valid, data and its mask slice,
// fanned out as wires to up to BRANCH children.
module hi_fanout_stage #(
    parameter int WIDTH  = 1,
    parameter int MASK_W = 1,
    parameter int FANOUT = 1
) (
    input  logic                      clk1,
    input  logic                      rst,
    input  logic                      src_valid,
    input  logic [WIDTH-1:0]          src_data,
    input  logic [MASK_W-1:0]         src_mask,
    output logic [FANOUT-1:0]         fan_valid,
    output logic [FANOUT*WIDTH-1:0]   fan_data,
    output logic [MASK_W-1:0]         fan_mask
);

    (* keep = "true" *) logic              valid_r;
    (* keep = "true" *) logic [WIDTH-1:0]  data_r;
    (* keep = "true" *) logic [MASK_W-1:0] mask_r;

    // Node register; every node is its own copy so repeater repair can split the net here.
    always_ff @(posedge clk1) begin
        if (rst) begin
            valid_r <= 1'b0;
            data_r  <= '0;
            mask_r  <= '0;
        end else begin
            valid_r <= src_valid;
            data_r  <= src_data;
            mask_r  <= src_mask;
        end
    end

    assign fan_valid = {FANOUT{valid_r}};
    assign fan_data  = {FANOUT{data_r}};
    assign fan_mask  = mask_r;

endmodule

// File: rtl/hi_fanout_tree.sv
// Distributes one word per cycle to NUM_LOADS masked load registers through a
// registered fanout tree: driver stage, LEVELS node levels, then the loads.
module hi_fanout_tree
    import hi_fanout_pkg::*;
#(
    parameter int WIDTH     = 1,
    parameter int NUM_LOADS = 70,
    parameter int BRANCH    = 8
) (
    input  logic                          clk1,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [WIDTH-1:0]              in_data,
    input  logic [NUM_LOADS-1:0]          load_en,
    output logic [NUM_LOADS*WIDTH-1:0]    q,
    output logic                          q_valid,
    output logic [CNT_W-1:0]              cap_cnt
);

    localparam int LEVELS      = clog_branch(NUM_LOADS, BRANCH);
    localparam int LOAD_BASE   = slot_base(NUM_LOADS, BRANCH, LEVELS, LEVELS + 1);
    localparam int TOTAL_SLOTS = slot_base(NUM_LOADS, BRANCH, LEVELS, LEVELS + 2);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // A slot is one replicated copy of valid/data feeding one node (or one load);
    // slots are packed level after level, so no slot exists for an unused leaf.
    logic [TOTAL_SLOTS-1:0]       slot_vld_s;
    logic [TOTAL_SLOTS*WIDTH-1:0] slot_dat_s;
    logic [LEVELS:0][NUM_LOADS-1:0] lvl_mask_s;

    logic             q_valid_r;
    logic [CNT_W-1:0] cap_cnt_r;

    hi_fanout_stage #(
        .WIDTH  (WIDTH),
        .MASK_W (NUM_LOADS),
        .FANOUT (1)
    ) u_driver (
        .clk1      (clk1),
        .rst       (rst),
        .src_valid (in_valid),
        .src_data  (in_data),
        .src_mask  (load_en),
        .fan_valid (slot_vld_s[0:0]),
        .fan_data  (slot_dat_s[WIDTH-1:0]),
        .fan_mask  (lvl_mask_s[0])
    );

    for (genvar lv = 1; lv <= LEVELS; lv++) begin : g_lvl
        localparam int NODES    = nodes_at(NUM_LOADS, BRANCH, LEVELS, lv);
        localparam int NEXT     = nodes_at(NUM_LOADS, BRANCH, LEVELS, lv + 1);
        localparam int SPAN     = span_at(BRANCH, LEVELS, lv);
        localparam int IN_BASE  = slot_base(NUM_LOADS, BRANCH, LEVELS, lv);
        localparam int OUT_BASE = slot_base(NUM_LOADS, BRANCH, LEVELS, lv + 1);

        for (genvar k = 0; k < NODES; k++) begin : g_node
            // The last node of a level may own fewer children and a shorter mask slice.
            localparam int FAN = min_int(BRANCH, NEXT - k * BRANCH);
            localparam int MW  = min_int(SPAN, NUM_LOADS - k * SPAN);

            hi_fanout_stage #(
                .WIDTH  (WIDTH),
                .MASK_W (MW),
                .FANOUT (FAN)
            ) u_node (
                .clk1      (clk1),
                .rst       (rst),
                .src_valid (slot_vld_s[IN_BASE + k]),
                .src_data  (slot_dat_s[(IN_BASE + k) * WIDTH +: WIDTH]),
                .src_mask  (lvl_mask_s[lv - 1][k * SPAN +: MW]),
                .fan_valid (slot_vld_s[OUT_BASE + k * BRANCH +: FAN]),
                .fan_data  (slot_dat_s[(OUT_BASE + k * BRANCH) * WIDTH +: FAN * WIDTH]),
                .fan_mask  (lvl_mask_s[lv][k * SPAN +: MW])
            );
        end
    end

    for (genvar j = 0; j < NUM_LOADS; j++) begin : g_load
        logic [WIDTH-1:0] load_r;

        // Load register: captures only when its own leaf copy is valid and its mask bit is set.
        always_ff @(posedge clk1) begin
            if (rst) begin
                load_r <= '0;
            end else if (slot_vld_s[LOAD_BASE + j] && lvl_mask_s[LEVELS][j]) begin
                load_r <= slot_dat_s[(LOAD_BASE + j) * WIDTH +: WIDTH];
            end else begin
                load_r <= load_r;
            end
        end

        assign q[j * WIDTH +: WIDTH] = load_r;
    end

    // Delivery strobe, aligned with the load registers regardless of the mask.
    always_ff @(posedge clk1) begin
        if (rst) begin
            q_valid_r <= 1'b0;
        end else begin
            q_valid_r <= slot_vld_s[LOAD_BASE];
        end
    end

    // Saturating delivered-word counter, updated on the same edge as the loads.
    always_ff @(posedge clk1) begin
        if (rst) begin
            cap_cnt_r <= '0;
        end else if (slot_vld_s[LOAD_BASE] && (cap_cnt_r != CNT_MAX)) begin
            cap_cnt_r <= cap_cnt_r + CNT_W'(1'b1);
        end else begin
            cap_cnt_r <= cap_cnt_r;
        end
    end

    assign q_valid = q_valid_r;
    assign cap_cnt = cap_cnt_r;

endmodule
